// File: rtl/arf_rat_pkg.sv
// Shared definitions for the architectural register file and register alias
// table: sizes, register/tag/data types and the RAT entry layout.
package arf_rat_pkg;

    localparam int N_ARF_REGS     = 32;
    localparam int ARF_ID_WIDTH   = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int ROB_ID_WIDTH   = 4;

    typedef logic [ARF_ID_WIDTH-1:0]   arf_id_t;
    typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    // One alias-table entry: valid=1 means the register's newest value is
    // still in flight and will be produced by ROB entry rob_id.
    typedef struct packed {
        logic    valid;
        rob_id_t rob_id;
    } rat_entry_t;

    localparam int RAT_ENTRY_WIDTH = $bits(rat_entry_t);

endpackage

// File: rtl/arf_regfile.sv
// Architectural register file.
//   clk, rst_aH       : clock, asynchronous active-high reset (clears all regs)
//   we, waddr, wdata  : single write port (retire commit); writes to x0 ignored
//   raddr1 -> rdata1  : combinational read port 1, x0 reads as zero
//   raddr2 -> rdata2  : combinational read port 2, x0 reads as zero
// Reads return pre-edge contents; there is no write-to-read bypass.
module arf_regfile
    import arf_rat_pkg::*;
(
    input  logic      clk,
    input  logic      rst_aH,
    input  logic      we,
    input  arf_id_t   waddr,
    input  reg_data_t wdata,
    input  arf_id_t   raddr1,
    output reg_data_t rdata1,
    input  arf_id_t   raddr2,
    output reg_data_t rdata2
);

    reg_data_t regs [N_ARF_REGS];

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            for (int i = 0; i < N_ARF_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 is forced to zero on the read side as well, so it stays zero even
    // if the storage location were ever disturbed.
    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/arf_rat.sv
// Architectural register file plus register alias table.
//   clk, rst_aH                      : clock, asynchronous active-high reset
//   dispatch_valid, dispatch_ready   : dispatch fires on valid & ready
//   dispatch_dst_valid/_arf_id       : destination written by the dispatching op
//   dispatch_rob_id                  : ROB tag allocated to that op
//   srcN_arf_id                      : source register lookups (N = 1, 2)
//   srcN_renamed/_rob_id/_arf_data   : in-flight tag or committed value
//   retire, retire_rob_id/_arf_id/_reg_data : ROB commit of a register write
//   flush                            : redirect flush, drops every mapping
// Handshake: a dispatch is consumed on the rising edge where dispatch_valid and
// dispatch_ready are both high; this block never back-pressures, so it has no
// ready output of its own (the ROB drives dispatch_ready). retire is a
// one-cycle strobe with no handshake.
// Source lookups are combinational from pre-edge state: a same-cycle dispatch
// or retire is not visible until the next cycle.
module arf_rat
    import arf_rat_pkg::*;
(
    input  logic      clk,
    input  logic      rst_aH,
    input  logic      dispatch_valid,
    input  logic      dispatch_ready,
    input  logic      dispatch_dst_valid,
    input  arf_id_t   dispatch_dst_arf_id,
    input  rob_id_t   dispatch_rob_id,
    input  arf_id_t   src1_arf_id,
    output logic      src1_renamed,
    output rob_id_t   src1_rob_id,
    output reg_data_t src1_arf_data,
    input  arf_id_t   src2_arf_id,
    output logic      src2_renamed,
    output rob_id_t   src2_rob_id,
    output reg_data_t src2_arf_data,
    input  logic      retire,
    input  rob_id_t   retire_rob_id,
    input  arf_id_t   retire_arf_id,
    input  reg_data_t retire_reg_data,
    input  logic      flush
);

    rat_entry_t rat [N_ARF_REGS];

    logic dispatch_fire;
    logic retire_clear;

    assign dispatch_fire = dispatch_valid && dispatch_ready && dispatch_dst_valid
                           && (dispatch_dst_arf_id != '0) && !flush;

    // Only the producer that still owns the mapping may clear it; if a
    // younger op has since been renamed onto the register, keep its tag.
    assign retire_clear = retire && (retire_arf_id != '0)
                          && rat[retire_arf_id].valid
                          && (rat[retire_arf_id].rob_id == retire_rob_id);

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            for (int i = 0; i < N_ARF_REGS; i++) begin
                rat[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < N_ARF_REGS; i++) begin
                rat[i].valid <= 1'b0;
            end
        end else begin
            if (retire_clear) begin
                rat[retire_arf_id].valid <= 1'b0;
            end
            // Placed after the retire clear so a same-register dispatch wins.
            if (dispatch_fire) begin
                rat[dispatch_dst_arf_id] <= '{valid: 1'b1, rob_id: dispatch_rob_id};
            end
        end
    end

    // The ARF write happens on every retire, flush or not.
    arf_regfile u_regfile (
        .clk    (clk),
        .rst_aH (rst_aH),
        .we     (retire),
        .waddr  (retire_arf_id),
        .wdata  (retire_reg_data),
        .raddr1 (src1_arf_id),
        .rdata1 (src1_arf_data),
        .raddr2 (src2_arf_id),
        .rdata2 (src2_arf_data)
    );

    assign src1_renamed = (src1_arf_id != '0) && rat[src1_arf_id].valid;
    assign src1_rob_id  = rat[src1_arf_id].rob_id;
    assign src2_renamed = (src2_arf_id != '0) && rat[src2_arf_id].valid;
    assign src2_rob_id  = rat[src2_arf_id].rob_id;

endmodule

// File: doc/arf_rat.md
Name: arf_rat

Overview:
- Architectural register file (ARF) plus register alias table (RAT); consumer end of the ROB retire interface.
- Also the issuer of the ROB source-lookup tags.
- At dispatch it supplies each source's ARF data or in-flight ROB tag, and records the new destination mapping.
- At retire it commits data to the ARF and clears stale mappings; a redirect flush drops all mappings.

Parameters:
- N_ARF_REGS, 32, number of architectural integer registers (x0 hardwired zero).
- ARF_ID_WIDTH, 5, log2(N_ARF_REGS).
- REG_DATA_WIDTH, 32, register data width.
- ROB_ID_WIDTH, 4, ROB tag width (ROB depth 2^ROB_ID_WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_aH  in  1  asynchronous, active-high reset.
- dispatch_valid  in  1  dispatch request from instruction FIFO.
- dispatch_ready  in  1  ROB can accept; dispatch fires when valid & ready.
- dispatch_dst_valid  in  1  instruction writes a destination register.
- dispatch_dst_arf_id  in  ARF_ID_WIDTH  destination register.
- dispatch_rob_id  in  ROB_ID_WIDTH  ROB tag allocated to this instruction.
- src1_arf_id  in  ARF_ID_WIDTH  source 1 register.
- src1_renamed  out  1  1 = value in flight; use src1_rob_id with ROB read port.
- src1_rob_id  out  ROB_ID_WIDTH  producing ROB tag (valid when renamed).
- src1_arf_data  out  REG_DATA_WIDTH  committed value (valid when not renamed).
- src2_arf_id, src2_renamed, src2_rob_id, src2_arf_data: identical to src1.
- retire  in  1  ROB retires an ARF-writing instruction.
- retire_rob_id  in  ROB_ID_WIDTH  tag of retiring entry.
- retire_arf_id  in  ARF_ID_WIDTH  destination of retiring entry.
- retire_reg_data  in  REG_DATA_WIDTH  value to commit.
- flush  in  1  redirect flush (ROB retire_redirect_pc_valid).

Behaviour:
- State:
  - arf[N_ARF_REGS] of REG_DATA_WIDTH.
  - rat[N_ARF_REGS] of {valid, rob_id}.
- Reset (async, rst_aH=1):
  - All arf = 0; all rat.valid = 0.
  - Outputs follow combinationally: renamed=0, arf_data=0, rob_id=rat content (0).
  - Reset mid-operation discards all state immediately, with no clock needed.
- Source lookup: purely combinational, 0-cycle latency, from pre-edge state. No bypass of same-cycle writes:
  - Same-cycle retire: the retiring ROB entry is still readable from the ROB that cycle.
  - Same-cycle dispatch: sources must see the older mapping (e.g. add x1,x1,x2).
- x0: src lookup with arf_id=0 gives renamed=0, arf_data=0. Dispatch or retire to x0 changes no state.
- Dispatch fire (valid & ready & dst_valid & dst!=0 & !flush): at the edge, rat[dst] = {1, dispatch_rob_id}. Overwrites any existing mapping.
- Retire (retire & retire_arf_id != 0):
  - At the edge, arf[retire_arf_id] = retire_reg_data.
  - rat[retire_arf_id].valid is cleared only if valid=1 and rob_id == retire_rob_id. Otherwise a younger producer owns the register and the mapping is kept.
- Dispatch and retire to the same register in one cycle: the dispatch mapping wins (valid=1, new tag); the ARF write still happens.
- Flush: at the edge, all rat.valid = 0.
  - A concurrent dispatch is dropped from the RAT.
  - A concurrent retire still writes the ARF. The ROB never asserts retire with a mispredicting entry, but the ARF write is required regardless.
- No handshake outputs; the block is always ready. The ROB owns dispatch_ready.
- Widths: no arithmetic; tags compared with full ROB_ID_WIDTH equality.

Decomposition:
- Shared package (global defs):
  - arf_id_t, rob_id_t, reg_data_t (existing).
  - New rat_entry_t {valid, rob_id_t rob_id} and RAT_ENTRY_WIDTH.
  - N_ARF_REGS constant.
- One natural sub-module, arf_regfile:
  - 1 write port (retire), 2 combinational read ports, x0 forced to zero, async active-high reset.
- RAT logic and tag-match clear stay in arf_rat.

Test Plan:
- Reset then read src1=5, src2=0 -> renamed=0/0, data=0/0; write x0 via retire data 0xDEAD -> src x0 still reads 0.
- Dispatch dst=x3 rob_id=7 (valid, ready) with src1=x3 in the same cycle -> src1_renamed=0 that cycle; next cycle src1=x3 -> renamed=1, rob_id=7.
- Retire x3 rob_id=7 data 0x1234 -> next cycle x3 renamed=0, arf_data=0x1234.
- Dispatch x3 tag 2, then x3 tag 5, then retire x3 tag 2 data 0xAA -> x3 stays renamed with tag 5, arf[x3]=0xAA; retire tag 5 -> unrenamed.
- Same-cycle dispatch x4 tag 9 and retire x4 tag 1 (x4 mapped to tag 1) -> x4 renamed, tag 9, arf[x4]=retire data.
- Map x1, x2, x6; assert flush with concurrent dispatch x7 tag 3 -> next cycle all sources renamed=0, x7 unmapped. Separately, assert rst_aH between edges -> outputs zero immediately.
